// File: rtl/branch_seq_ctrl_pkg.sv
// Shared constants for the ID-stage branch sequencer: MIPS branch opcodes,
// REGIMM sub-ops, the zero word and the sequencer state encoding.
package branch_seq_ctrl_pkg;

    localparam logic [5:0]  REGIMM_INST = 6'b000001;
    localparam logic [5:0]  BEQ         = 6'b000100;
    localparam logic [5:0]  BNE         = 6'b000101;
    localparam logic [5:0]  BLEZ        = 6'b000110;
    localparam logic [5:0]  BGTZ        = 6'b000111;

    localparam logic [4:0]  BLTZ        = 5'b00000;
    localparam logic [4:0]  BGEZ        = 5'b00001;
    localparam logic [4:0]  BLTZAL      = 5'b10000;
    localparam logic [4:0]  BGEZAL      = 5'b10001;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        BSC_IDLE     = 2'd0,
        BSC_WAIT     = 2'd1,
        BSC_RESOLVE  = 2'd2,
        BSC_REDIRECT = 2'd3
    } bsc_state_t;

    // True for any op/rt pair the sequencer knows how to resolve.
    function automatic logic is_known_branch(input logic [5:0] op, input logic [4:0] rt);
        logic known;
        case (op)
            BEQ, BNE, BLEZ, BGTZ: known = 1'b1;
            REGIMM_INST:          known = (rt == BLTZ) || (rt == BGEZ) ||
                                          (rt == BLTZAL) || (rt == BGEZAL);
            default:              known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic is_link_branch(input logic [5:0] op, input logic [4:0] rt);
        return (op == REGIMM_INST) && ((rt == BLTZAL) || (rt == BGEZAL));
    endfunction

endpackage

// File: rtl/branch_seq_ctrl_perf_cnt.sv
// Branch performance counters (redirects, taken redirects, stall cycles).
// Only instantiated when BRANCH_SEQ_PERF_EN is defined; counters wrap.
module branch_perf_cnt (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect,
    input  logic        taken,
    input  logic        stall,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_taken,
    output logic [31:0] perf_stall_cycles
);

    // Free-running event counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_branches     <= 32'd0;
            perf_taken        <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (redirect) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (redirect && taken) begin
                perf_taken <= perf_taken + 32'd1;
            end
            if (stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// ID-stage branch sequencer: waits for forwardable operands, samples the
// comparator, then pulses a PC redirect / link write. Optional BRANCH_SEQ_PERF_EN.
module branch_seq_ctrl
    import branch_seq_ctrl_pkg::*;
#(
    parameter int MAX_WAIT   = 16,
    parameter int WAIT_CNT_W = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rt,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic        opnd_ready,
    input  logic        cmp_taken,
    input  logic        id_flush,
    output logic        id_stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        busy,
    output logic        hazard_err
`ifdef BRANCH_SEQ_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_taken,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_SAT   = {WAIT_CNT_W{1'b1}};

    bsc_state_t             state_r, state_nxt_s;
    logic                   accept_s;
    logic [31:0]            pc_r, target_r, pc_plus8_s;
    logic [5:0]             op_r;
    logic [4:0]             rt_r;
    logic [WAIT_CNT_W-1:0]  wait_cnt_r;
    logic [31:0]            redirect_pc_r, link_addr_r;
    logic                   link_r, hazard_err_r;

    assign accept_s   = id_valid & id_is_branch & (state_r == BSC_IDLE) & ~id_flush;
    assign pc_plus8_s = pc_r + 32'd8;

    // Next-state logic; a flush always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (id_flush) begin
            state_nxt_s = BSC_IDLE;
        end else begin
            case (state_r)
                BSC_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = opnd_ready ? BSC_RESOLVE : BSC_WAIT;
                    end else begin
                        state_nxt_s = BSC_IDLE;
                    end
                end
                BSC_WAIT: begin
                    if (opnd_ready) begin
                        state_nxt_s = BSC_RESOLVE;
                    end else begin
                        state_nxt_s = BSC_WAIT;
                    end
                end
                BSC_RESOLVE:  state_nxt_s = BSC_REDIRECT;
                BSC_REDIRECT: state_nxt_s = BSC_IDLE;
                default:      state_nxt_s = BSC_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= BSC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Branch capture on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r     <= ZeroWord;
            target_r <= ZeroWord;
            op_r     <= 6'd0;
            rt_r     <= 5'd0;
        end else if (accept_s) begin
            pc_r     <= id_pc;
            target_r <= id_target;
            op_r     <= id_op;
            rt_r     <= id_rt;
        end
    end

    // Operand-wait counter and sticky hazard flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r   <= '0;
            hazard_err_r <= 1'b0;
        end else begin
            if (state_r == BSC_WAIT && state_nxt_s == BSC_WAIT) begin
                wait_cnt_r <= (wait_cnt_r == WAIT_SAT) ? wait_cnt_r : wait_cnt_r + 1'b1;
            end else begin
                wait_cnt_r <= '0;
            end
            if (state_r == BSC_WAIT && wait_cnt_r == WAIT_LIMIT) begin
                hazard_err_r <= 1'b1;
            end
        end
    end

    // Resolve: unknown ops fall through to pc+8 like a not-taken branch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_pc_r <= ZeroWord;
            link_addr_r   <= ZeroWord;
            link_r        <= 1'b0;
        end else if (state_r == BSC_RESOLVE) begin
            redirect_pc_r <= (cmp_taken && is_known_branch(op_r, rt_r)) ? target_r : pc_plus8_s;
            link_addr_r   <= pc_plus8_s;
            link_r        <= is_link_branch(op_r, rt_r);
        end
    end

    assign id_stall    = accept_s | (state_r == BSC_WAIT) | (state_r == BSC_RESOLVE);
    assign pc_redirect = (state_r == BSC_REDIRECT) & ~id_flush;
    assign link_we     = (state_r == BSC_REDIRECT) & link_r & ~id_flush;
    assign redirect_pc = redirect_pc_r;
    assign link_addr   = link_addr_r;
    assign busy        = (state_r != BSC_IDLE);
    assign hazard_err  = hazard_err_r;

`ifdef BRANCH_SEQ_PERF_EN
    logic taken_r;

    // Taken flag of the branch currently being redirected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            taken_r <= 1'b0;
        end else if (state_r == BSC_RESOLVE) begin
            taken_r <= cmp_taken & is_known_branch(op_r, rt_r);
        end
    end

    branch_perf_cnt u_perf (
        .clk               (clk),
        .resetn            (resetn),
        .redirect          (pc_redirect),
        .taken             (taken_r),
        .stall             (id_stall),
        .perf_branches     (perf_branches),
        .perf_taken        (perf_taken),
        .perf_stall_cycles (perf_stall_cycles)
    );
`endif

endmodule
